// File: rtl/asp_pkg.sv
// Shared opcode constants and executor state encoding used by the control unit and op_executor.
package asp_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_TXE = 2'b01;
    localparam logic [1:0] OP_RXA = 2'b10;
    localparam logic [1:0] OP_LOG = 2'b11;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StTxWait = 2'b01,
        StRxOut  = 2'b10,
        StLogWr  = 2'b11
    } exec_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count != '1)) begin
            count_d = count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

endmodule

// File: rtl/op_executor.sv
// Executes NOP/TXE/RXA/LOG opcodes between the control unit and the DPP/ND datapaths.
module op_executor
    import asp_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        opcode_in,
    output logic              busy_out,
    input  logic [DATA_W-1:0] dpp_data_in,
    output logic              dpp_pop_out,
    output logic [DATA_W-1:0] tx_data_out,
    output logic              tx_valid_out,
    input  logic              tx_ready_in,
    input  logic [DATA_W-1:0] rx_data_in,
    output logic              rx_ack_out,
    output logic [DATA_W-1:0] rx_data_out,
    output logic              rx_valid_out,
    output logic              log_we_out,
    output logic [DATA_W-1:0] log_data_out,
    output logic [CNT_W-1:0]  log_tag_out,
    output logic              timeout_out,
    output logic [CNT_W-1:0]  txe_count_out,
    output logic [CNT_W-1:0]  rxa_count_out
);

    // Wait counter only has to reach TIMEOUT-1.
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    exec_state_e       state_q, state_d;
    logic              log_flag_q;
    logic              accept_tx, accept_rx;
    logic              txe_inc, rxa_inc, wait_inc, wait_clr, timeout_d;
    logic [WAIT_W-1:0] wait_count;
    logic [CNT_W-1:0]  rxa_tag;

    always_comb begin
        state_d   = state_q;
        accept_tx = 1'b0;
        accept_rx = 1'b0;
        txe_inc   = 1'b0;
        rxa_inc   = 1'b0;
        wait_inc  = 1'b0;
        wait_clr  = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (opcode_in == OP_TXE) begin
                    accept_tx = 1'b1;
                    wait_clr  = 1'b1;
                    state_d   = StTxWait;
                end else if ((opcode_in == OP_RXA) || (opcode_in == OP_LOG)) begin
                    accept_rx = 1'b1;
                    state_d   = StRxOut;
                end
            end
            StTxWait: begin
                // Handshake wins over timeout in the last allowed cycle.
                if (tx_ready_in) begin
                    txe_inc = 1'b1;
                    state_d = StIdle;
                end else if (wait_count == WAIT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            StRxOut: begin
                rxa_inc = 1'b1;
                state_d = log_flag_q ? StLogWr : StIdle;
            end
            StLogWr: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Tag is the RXA count after the increment happening at this same edge.
    assign rxa_tag = (rxa_count_out == '1) ? rxa_count_out : rxa_count_out + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            log_flag_q   <= 1'b0;
            busy_out     <= 1'b0;
            dpp_pop_out  <= 1'b0;
            tx_data_out  <= '0;
            tx_valid_out <= 1'b0;
            rx_ack_out   <= 1'b0;
            rx_data_out  <= '0;
            rx_valid_out <= 1'b0;
            log_we_out   <= 1'b0;
            log_data_out <= '0;
            log_tag_out  <= '0;
            timeout_out  <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_out     <= (state_d != StIdle);
            dpp_pop_out  <= accept_tx;
            tx_valid_out <= (state_d == StTxWait);
            rx_ack_out   <= (state_d == StRxOut);
            rx_valid_out <= (state_d == StRxOut);
            log_we_out   <= (state_d == StLogWr);
            timeout_out  <= timeout_d;
            if (accept_tx) begin
                tx_data_out <= dpp_data_in;
            end
            if (accept_rx) begin
                rx_data_out <= rx_data_in;
                log_flag_q  <= (opcode_in == OP_LOG);
            end
            if (state_d == StLogWr) begin
                log_data_out <= rx_data_out;
                log_tag_out  <= rxa_tag;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_txe_count (
        .clk   (clk),
        .reset (reset),
        .inc   (txe_inc),
        .clear (1'b0),
        .count (txe_count_out)
    );

    sat_counter #(.CNT_W(CNT_W)) u_rxa_count (
        .clk   (clk),
        .reset (reset),
        .inc   (rxa_inc),
        .clear (1'b0),
        .count (rxa_count_out)
    );

    sat_counter #(.CNT_W(WAIT_W)) u_wait_count (
        .clk   (clk),
        .reset (reset),
        .inc   (wait_inc),
        .clear (wait_clr),
        .count (wait_count)
    );

endmodule

// File: doc/op_executor.md
# op_executor

Executes the 2-bit opcode stream issued by the control unit (NOP, TXE, RXA, LOG): moves one word from the DPP to the network-device transmit port, or captures one word from the network-device receive port and forwards it, optionally writing a log record. It sits between the control unit and the DPP/ND datapaths. It reports `busy_out` while a command is in flight; opcodes presented while busy are ignored.

## Interface
- `DATA_W`, 32, data word width
- `CNT_W`, 16, width of the TXE/RXA completion counters and the log tag
- `TIMEOUT`, 255, maximum cycles `tx_valid_out` waits for `tx_ready_in` (≥1)

- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `opcode_in`  in  2  00 NOP, 01 TXE, 10 RXA, 11 LOG; sampled only in IDLE
- `busy_out`  out  1  high whenever state ≠ IDLE
- `dpp_data_in`  in  DATA_W  head word of the DPP queue
- `dpp_pop_out`  out  1  one-cycle pulse that consumes the DPP head word
- `tx_data_out`  out  DATA_W  word offered to the ND
- `tx_valid_out`  out  1  transmit valid
- `tx_ready_in`  in  1  ND transmit ready
- `rx_data_in`  in  DATA_W  ND received word
- `rx_ack_out`  out  1  one-cycle pulse that acknowledges the ND received word
- `rx_data_out`  out  DATA_W  forwarded received word
- `rx_valid_out`  out  1  one-cycle pulse; no backpressure
- `log_we_out`  out  1  one-cycle log write strobe
- `log_data_out`  out  DATA_W  logged word
- `log_tag_out`  out  CNT_W  RXA count at the time of logging
- `timeout_out`  out  1  one-cycle pulse after an abandoned TXE
- `txe_count_out`, `rxa_count_out`  out  CNT_W  saturating completion counters

## Operation
- States: IDLE, TX_WAIT, RX_OUT, LOG_WR. All outputs are registered.
- IDLE, opcode TXE: latch `dpp_data_in` into `tx_data_out`, clear the wait counter, go to TX_WAIT.
- IDLE, opcode RXA or LOG: latch `rx_data_in`, record a log flag (1 for LOG), go to RX_OUT.
- IDLE, opcode NOP: remain in IDLE.
- TX_WAIT:
  - `tx_valid_out`=1. `dpp_pop_out`=1 only in the first TX_WAIT cycle.
  - On `tx_valid_out && tx_ready_in`: increment `txe_count_out`, go to IDLE.
  - Otherwise increment the wait counter. If it equals TIMEOUT-1, go to IDLE and pulse `timeout_out` in the following cycle. The word is dropped and the count is not incremented.
  - If `tx_ready_in` is high in the last allowed cycle, the transfer completes and no timeout is reported.
- RX_OUT (one cycle):
  - `rx_ack_out`=1, `rx_valid_out`=1, `rx_data_out`=captured word.
  - Increment `rxa_count_out`.
  - Next state is LOG_WR if the log flag is set, else IDLE.
- LOG_WR (one cycle): `log_we_out`=1, `log_data_out`=captured word, `log_tag_out`=the already-incremented `rxa_count_out`. Next state IDLE.
- Counters saturate at 2^CNT_W−1 and do not wrap.
- Reset:
  - State returns to IDLE.
  - All outputs, counters and data registers go to 0.
  - Any in-flight word is discarded with no pop, ack, valid, log or timeout pulse.
  - Reset takes priority over every other event, including a handshake in the same cycle.

## Timing
- Opcode accepted at edge E. The first command cycle (TX_WAIT or RX_OUT) starts at E, and `busy_out` rises in that cycle.
- TXE with ready already high: busy for 1 cycle, `txe_count_out` updates at E+1.
- RXA: busy for 1 cycle. LOG: busy for 2 cycles, with `log_we_out` in the second.
- After every command, one IDLE cycle precedes the next acceptance. The back-to-back command period is therefore 2 cycles (TXE, RXA) or 3 (LOG).
- TXE timeout: `tx_valid_out` is high for exactly TIMEOUT cycles, and `timeout_out` pulses in the following IDLE cycle.

## Structure
- Shared package `asp_pkg`:
  - opcode constants OP_NOP, OP_TXE, OP_RXA, OP_LOG, shared with the control unit;
  - executor state encoding.
- One sub-module, `sat_counter` (parameter CNT_W; inputs inc and clear), instantiated for the TXE count, the RXA count and the TX wait counter.

## Test plan
- Reset, then hold NOP for 10 cycles: `busy_out` and all outputs stay 0.
- TXE with `dpp_data_in`=0xDEADBEEF and `tx_ready_in`=1:
  - one cycle with `tx_valid_out`=1, `dpp_pop_out`=1 and `tx_data_out`=0xDEADBEEF;
  - then `txe_count_out`=1 and `busy_out`=0.
- TXE with `tx_ready_in`=0 and TIMEOUT=4:
  - `tx_valid_out` high for 4 cycles, then a `timeout_out` pulse;
  - `txe_count_out` stays 0.
- Same setup, with ready raised in the 4th cycle: transfer completes, no timeout.
- LOG with `rx_data_in`=0x12345678:
  - RX_OUT cycle: `rx_ack_out`=1, `rx_valid_out`=1, `rx_data_out`=0x12345678;
  - next cycle: `log_we_out`=1, `log_data_out`=0x12345678, `log_tag_out`=1.
- Continuous RXA with CNT_W=4: `rxa_count_out` saturates at 15.
- Reset asserted during TX_WAIT: outputs go to 0 at the next cycle with no stray pulses.
